// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: shares one SPI flash/PSRAM memory controller between two requesters.
//   Port 0 is the CPU sequencer and port 1 is a secondary master (boot copy / DMA).
//   The arbiter serialises whole transactions. It returns read data and a one-cycle done
//   pulse to the owner, and a watchdog aborts any transaction that hangs.
// Ports:
//   clk_in, reset_n_in        clock (rising edge) and asynchronous active-low reset
//   req_in[1:0]               per-port request (bit p = port p)
//   addrN_in/typeN_in/wdataN_in  per-port address, type (0 idle, 1 imem rd, 2 dmem rd,
//                             3 dmem wr) and PSRAM write byte
//   gnt_out/done_out/err_out  one-hot owner, completion pulse, watchdog-abort pulse
//   rdata_out                 last read data (IMEM 16 bit, DMEM zero-extended byte)
//   mem_*_out / *_in          controller request and response interface
module spi_mem_arbiter #(
  parameter bit          RR_EN          = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TO_W           = 13
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic [1:0]  req_in,
  input  logic [15:0] addr0_in,
  input  logic [15:0] addr1_in,
  input  logic [1:0]  type0_in,
  input  logic [1:0]  type1_in,
  input  logic [7:0]  wdata0_in,
  input  logic [7:0]  wdata1_in,
  output logic [1:0]  gnt_out,
  output logic [1:0]  done_out,
  output logic [1:0]  err_out,
  output logic [15:0] rdata_out,
  output logic [15:0] mem_addr_out,
  output logic        mem_addr_valid_out,
  output logic [1:0]  mem_type_out,
  output logic [7:0]  mem_wdata_out,
  input  logic        mem_busy_in,
  input  logic        flash_valid_in,
  input  logic [15:0] flash_data_in,
  input  logic        psram_valid_in,
  input  logic [7:0]  psram_data_in
);

  localparam logic [1:0] TypeIdle   = 2'd0;
  localparam logic [1:0] TypeImem   = 2'd1;
  localparam logic [1:0] TypeDmemRd = 2'd2;
  localparam logic [1:0] TypeDmemWr = 2'd3;

  localparam bit            ToEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [15:0]     addr_q, addr_d;
  logic [1:0]      type_q, type_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            last_q, last_d;       // port granted most recently
  logic [TO_W-1:0] wd_q, wd_d;
  logic            busy_prev_q, busy_prev_d;

  logic valid0, valid1, pick1, complete, timeout;

  // Requests carrying type IDLE are never eligible.
  assign valid0 = req_in[0] && (type0_in != TypeIdle);
  assign valid1 = req_in[1] && (type1_in != TypeIdle);

  // Port 1 wins when it is alone, or on a tie when round-robin says it is its turn.
  assign pick1 = valid1 && (!valid0 || (RR_EN && !last_q));

  assign timeout = ToEn && (wd_q == ToLast);

  // State register.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= StIdle;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      err_q       <= 2'b00;
      rdata_q     <= 16'h0000;
      addr_q      <= 16'h0000;
      type_q      <= TypeIdle;
      wdata_q     <= 8'h00;
      last_q      <= 1'b1;
      wd_q        <= '0;
      busy_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      type_q      <= type_d;
      wdata_q     <= wdata_d;
      last_q      <= last_d;
      wd_q        <= wd_d;
      busy_prev_q <= busy_prev_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = 2'b00;
    err_d       = 2'b00;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    type_d      = type_q;
    wdata_d     = wdata_q;
    last_d      = last_q;
    wd_d        = wd_q;
    busy_prev_d = mem_busy_in;
    complete    = 1'b0;

    unique case (type_q)
      TypeImem:   complete = flash_valid_in;
      TypeDmemRd: complete = psram_valid_in;
      TypeDmemWr: complete = busy_prev_q && !mem_busy_in;  // busy falling edge
      default:    complete = 1'b0;
    endcase

    unique case (state_q)
      StIdle: begin
        if ((valid0 || valid1) && !mem_busy_in) begin
          gnt_d   = pick1 ? 2'b10 : 2'b01;
          addr_d  = pick1 ? addr1_in : addr0_in;
          type_d  = pick1 ? type1_in : type0_in;
          wdata_d = pick1 ? wdata1_in : wdata0_in;
          last_d  = pick1;
          wd_d    = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (timeout) begin
          done_d  = gnt_q;
          err_d   = gnt_q;
          gnt_d   = 2'b00;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + TO_W'(1);
          if (mem_busy_in) state_d = StWait;
        end
      end
      StWait: begin
        // Completion takes precedence over a coincident watchdog expiry.
        if (complete) begin
          if (type_q == TypeImem) rdata_d = flash_data_in;
          else if (type_q == TypeDmemRd) rdata_d = {8'h00, psram_data_in};
          done_d  = gnt_q;
          gnt_d   = 2'b00;
          state_d = StIdle;
        end else if (timeout) begin
          done_d  = gnt_q;
          err_d   = gnt_q;
          gnt_d   = 2'b00;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    mem_addr_valid_out = 1'b0;
    unique case (state_q)
      StIssue: mem_addr_valid_out = 1'b1;
      default: mem_addr_valid_out = 1'b0;
    endcase
    gnt_out       = gnt_q;
    done_out      = done_q;
    err_out       = err_q;
    rdata_out     = rdata_q;
    mem_addr_out  = addr_q;
    mem_type_out  = type_q;
    mem_wdata_out = wdata_q;
  end

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
- Two-port arbiter that shares the single SPI flash/PSRAM memory controller between two requesters.
- Port 0 is the CPU sequencer (instruction fetch, load/store). Port 1 is a secondary master, e.g. a boot-copy or DMA engine.
- Sits between the requesters and the controller's addr/valid/type/data interface.
- Serialises whole transactions, returns read data and a completion pulse to the owner, and aborts hung transactions via a watchdog.

Parameters:
- RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins.
- TIMEOUT_CYCLES, 4096, cycles from issue to forced abort; 0 disables the watchdog.
- TO_W, 13, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk_in  input  1  system clock, rising edge
- reset_n_in  input  1  asynchronous, active-low reset
- req_in  input  2  per-port request, bit p = port p
- addr0_in / addr1_in  input  16  transaction address
- type0_in / type1_in  input  2  0=IDLE, 1=IMEM_READ, 2=DMEM_READ, 3=DMEM_WRITE
- wdata0_in / wdata1_in  input  8  PSRAM write data
- gnt_out  output  2  one-hot; owner of the current transaction
- done_out  output  2  one-cycle completion pulse to the owner
- err_out  output  2  one-cycle pulse, coincident with done, on watchdog abort
- rdata_out  output  16  read data; IMEM = 16 bit, DMEM = {8'h00, byte}
- mem_addr_out  output  16  to controller addr_in
- mem_addr_valid_out  output  1  to controller addr_valid_in
- mem_type_out  output  2  to controller mem_type_in
- mem_wdata_out  output  8  to controller psram_data_in
- mem_busy_in  input  1  controller busy_out
- flash_valid_in  input  1  controller flash_data_valid_out
- flash_data_in  input  16  controller flash_data_out
- psram_valid_in  input  1  controller psram_data_valid_out
- psram_data_in  input  8  controller psram_data_out

Behaviour:
- Reset (async assert on reset_n_in low):
  - all outputs 0; state IDLE; watchdog 0; last_grant = 1, so port 0 wins the first tie.
  - Release is synchronous to clk_in.
  - Reset mid-transaction abandons it silently: no done, no err.
- Requester handshake:
  - Requester raises req with addr/type/wdata stable, and holds them until its done pulse.
  - req with type = IDLE is ignored and never granted.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - Proceeds only when at least one valid req is present and mem_busy_in = 0.
  - One valid req: grant that port.
  - Both valid, RR_EN=1: grant the port != last_grant. RR_EN=0: grant port 0.
  - On the grant edge: latch addr/type/wdata into internal registers, set gnt_out, update last_grant, clear the watchdog, go to ISSUE.
  - Latency: req sampled at edge N gives gnt_out and mem_addr_valid_out high after edge N+1.
- ISSUE:
  - mem_addr_valid_out = 1; mem_addr_out, mem_type_out, mem_wdata_out driven from the latched registers.
  - Stay until mem_busy_in = 1, then go to WAIT_DONE.
- WAIT_DONE:
  - mem_addr_valid_out = 0; mem_type_out and mem_addr_out remain held.
  - Completion rules:
    - IMEM_READ: on flash_valid_in.
    - DMEM_READ: on psram_valid_in.
    - DMEM_WRITE: on mem_busy_in falling (1 then 0).
  - A data-valid pulse of the wrong kind is ignored.
  - On completion edge: capture rdata_out (IMEM: flash_data_in; DMEM_READ: {8'h00, psram_data_in}; write: unchanged).
  - Same edge: pulse done_out[owner] for one cycle, clear gnt_out, return to IDLE.
  - Re-arbitration can happen in the cycle after done. Back-to-back transactions therefore have a 1-cycle IDLE gap.
- Watchdog:
  - Counts every cycle in ISSUE and WAIT_DONE.
  - When the count reaches TIMEOUT_CYCLES-1 with no completion, pulse done_out and err_out for the owner, leave rdata_out unchanged, return to IDLE.
  - Completion and timeout on the same edge: completion wins, err_out = 0.
- Owner drops req mid-transaction: ignored; the transaction completes and done_out still pulses.
- rdata_out holds its value until the next read completes.
- gnt_out and done_out are never asserted for both ports at once.

Test Plan:
- Single IMEM_READ on port 0, addr 0x0120: gnt_out=01 one cycle after req. Valid held until busy rises. After flash_valid_in with data 0xBEEF: done_out=01 for one cycle, rdata_out=0xBEEF, gnt_out=00.
- Simultaneous req=11 repeated four times, RR_EN=1: grant order 0,1,0,1. With RR_EN=0: 0,0,0,0 while port 0 keeps requesting.
- Port 1 DMEM_WRITE, addr 0x2040, wdata 0x5A: mem_wdata_out=0x5A. done_out=10 on the cycle busy falls; rdata_out unchanged.
- DMEM_READ returning psram 0x7C, with a stray flash_valid_in injected during WAIT_DONE: the stray pulse is ignored; rdata_out=0x007C on the psram pulse.
- TIMEOUT_CYCLES=16, busy stuck high: done_out=err_out=owner bit exactly 16 cycles after the grant, FSM back in IDLE. Repeat with completion on the timeout cycle: err_out=0.
- reset_n_in pulsed low during WAIT_DONE: outputs 0 immediately (async), no done_out. First request after release is served normally.
